crc_tx_serializer: RTL and testbench

CRC_TX_SERIALIZER -- requirements
Module: crc_tx_serializer

---
 rtl/crc_tx_serializer.sv | 163 ++++++++++++++++
 tb/tb_crc_tx_serializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/crc_tx_serializer.sv
// Serialises parallel payload words MSB first into a serial CRC engine and onto a line,
// then appends the engine's CRC result MSB first. All outputs are registered.
module crc_tx_serializer #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [CRC_W-1:0]  crc_seq,
    output logic              crc_data_in,
    output logic              crc_ctrl_en,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic              underrun
);

    localparam int MAX_W = (DATA_W > CRC_W) ? DATA_W : CRC_W;
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CNT_W-1:0] DATA_LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CRC_LAST_CNT  = CNT_W'(CRC_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CAP  = 2'd2,
        CRC  = 2'd3
    } state_t;

    state_t              state_r;
    logic [DATA_W-1:0]   shift_r;
    logic [CRC_W-1:0]    crc_sh_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                last_r;
    logic                in_ready_r;
    logic                crc_data_in_r;
    logic                crc_ctrl_en_r;
    logic                tx_bit_r;
    logic                tx_valid_r;
    logic                tx_sof_r;
    logic                tx_eof_r;
    logic                underrun_r;

    logic [DATA_W-1:0]   shift_nxt_s;
    logic [CRC_W-1:0]    crc_nxt_s;

    assign shift_nxt_s = shift_r << 1;
    assign crc_nxt_s   = crc_sh_r << 1;

    // Output registers hold the values for the cycle that follows each edge,
    // so they are computed from the state being entered.
    // Frame sequencing FSM with its registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            shift_r       <= '0;
            crc_sh_r      <= '0;
            cnt_r         <= '0;
            last_r        <= 1'b0;
            in_ready_r    <= 1'b1;
            crc_data_in_r <= 1'b0;
            crc_ctrl_en_r <= 1'b0;
            tx_bit_r      <= 1'b0;
            tx_valid_r    <= 1'b0;
            tx_sof_r      <= 1'b0;
            tx_eof_r      <= 1'b0;
            underrun_r    <= 1'b0;
        end else begin
            in_ready_r    <= 1'b0;
            crc_data_in_r <= 1'b0;
            crc_ctrl_en_r <= 1'b0;
            tx_bit_r      <= 1'b0;
            tx_valid_r    <= 1'b0;
            tx_sof_r      <= 1'b0;
            tx_eof_r      <= 1'b0;
            underrun_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        state_r       <= DATA;
                        shift_r       <= in_data;
                        last_r        <= in_last;
                        cnt_r         <= DATA_LAST_CNT;
                        tx_bit_r      <= in_data[DATA_W-1];
                        crc_data_in_r <= in_data[DATA_W-1];
                        tx_valid_r    <= 1'b1;
                        crc_ctrl_en_r <= 1'b1;
                        tx_sof_r      <= 1'b1;
                        in_ready_r    <= (DATA_W == 1) && !in_last;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_r != '0) begin
                        shift_r       <= shift_nxt_s;
                        cnt_r         <= cnt_r - CNT_W'(1);
                        tx_bit_r      <= shift_nxt_s[DATA_W-1];
                        crc_data_in_r <= shift_nxt_s[DATA_W-1];
                        tx_valid_r    <= 1'b1;
                        crc_ctrl_en_r <= 1'b1;
                        in_ready_r    <= (cnt_r == CNT_W'(1)) && !last_r;
                    end else if (last_r) begin
                        state_r <= CAP;
                    end else if (in_valid) begin
                        // Next word arrived on the final bit: continue without a bubble
                        shift_r       <= in_data;
                        last_r        <= in_last;
                        cnt_r         <= DATA_LAST_CNT;
                        tx_bit_r      <= in_data[DATA_W-1];
                        crc_data_in_r <= in_data[DATA_W-1];
                        tx_valid_r    <= 1'b1;
                        crc_ctrl_en_r <= 1'b1;
                        in_ready_r    <= (DATA_W == 1) && !in_last;
                    end else begin
                        state_r    <= IDLE;
                        underrun_r <= 1'b1;
                        in_ready_r <= 1'b1;
                    end
                end
                CAP: begin
                    state_r    <= CRC;
                    crc_sh_r   <= crc_seq;
                    cnt_r      <= CRC_LAST_CNT;
                    tx_bit_r   <= crc_seq[CRC_W-1];
                    tx_valid_r <= 1'b1;
                    tx_eof_r   <= (CRC_W == 1);
                end
                CRC: begin
                    if (cnt_r != '0) begin
                        crc_sh_r   <= crc_nxt_s;
                        cnt_r      <= cnt_r - CNT_W'(1);
                        tx_bit_r   <= crc_nxt_s[CRC_W-1];
                        tx_valid_r <= 1'b1;
                        tx_eof_r   <= (cnt_r == CNT_W'(1));
                    end else begin
                        state_r    <= IDLE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign crc_data_in = crc_data_in_r;
    assign crc_ctrl_en = crc_ctrl_en_r;
    assign tx_bit      = tx_bit_r;
    assign tx_valid    = tx_valid_r;
    assign tx_sof      = tx_sof_r;
    assign tx_eof      = tx_eof_r;
    assign underrun    = underrun_r;

endmodule

// File: tb/tb_crc_tx_serializer.sv
// Bench for crc_tx_serializer: a serial CRC-16 (0x8005) engine drives crc_seq, and every
// cycle of each frame is compared against a timeline built from the payload and its CRC.
module tb_crc_tx_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] crc_seq;
    logic        crc_data_in;
    logic        crc_ctrl_en;
    logic        tx_bit;
    logic        tx_valid;
    logic        tx_sof;
    logic        tx_eof;
    logic        underrun;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_no = 0;
    logic [7:0]  words[$];
    logic [15:0] crc_eng = 16'h0000;

    crc_tx_serializer #(.DATA_W(8), .CRC_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .crc_seq(crc_seq), .crc_data_in(crc_data_in), .crc_ctrl_en(crc_ctrl_en),
        .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_sof(tx_sof), .tx_eof(tx_eof),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] eng_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h8005 : 16'h0000);
    endfunction

    // External serial CRC engine, restarted on the first payload bit of each frame
    always @(posedge clk) begin
        if (crc_ctrl_en) crc_eng <= eng_step(tx_sof ? 16'h0000 : crc_eng, crc_data_in);
    end
    assign crc_seq = crc_eng;

    // Byte-wise CRC-16 reference over the queued payload
    function automatic logic [15:0] ref_crc();
        logic [15:0] c = 16'h0000;
        foreach (words[i]) begin
            c = c ^ {words[i], 8'h00};
            for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] pack_out();
        return {in_ready, tx_valid, tx_bit, tx_sof, tx_eof, crc_ctrl_en, crc_data_in, underrun};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame from an IDLE cycle (called #1 after a rising edge).
    // drop_at: index of a word withheld (underrun), rst_at: cycle index of a reset pulse.
    task automatic run_frame(input int drop_at, input int rst_at, input bit hold, input logic [15:0] crc);
        int n;
        int total;
        int w;
        int j;
        logic b;
        logic [7:0] e;
        n = words.size();
        total = n * 8 + 1 + 16;
        frame_no++;
        in_valid = 1'b1;
        in_data  = words[0];
        in_last  = (n == 1);
        @(negedge clk);
        check_val($sformatf("f%0d_idle", frame_no), {24'h0, pack_out()}, 32'h80);
        @(posedge clk);
        #1;
        for (int k = 0; k < total; k++) begin
            w = k / 8;
            if (k == rst_at) rst_n = 1'b0;
            if (k < n * 8 && k % 8 == 7 && w < n - 1 && w + 1 != drop_at) begin
                in_valid = 1'b1;
                in_data  = words[w + 1];
                in_last  = (w + 1 == n - 1);
            end else begin
                in_valid = hold;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end
            if (drop_at > 0 && k == drop_at * 8 - 1) in_valid = 1'b0;
            if (k < n * 8) begin
                b = words[w][7 - k % 8];
                e = {(k % 8 == 7 && w < n - 1), 1'b1, b, (k == 0), 1'b0, 1'b1, b, 1'b0};
            end else if (k == n * 8) begin
                e = 8'h00;
            end else begin
                j = k - n * 8 - 1;
                b = crc[15 - j];
                e = {1'b0, 1'b1, b, 1'b0, (j == 15), 3'b000};
            end
            @(negedge clk);
            check_val($sformatf("f%0d_k%0d", frame_no, k), {24'h0, pack_out()}, {24'h0, e});
            @(posedge clk);
            #1;
            if (k == rst_at) begin
                rst_n = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                check_val($sformatf("f%0d_post_rst", frame_no), {24'h0, pack_out()}, 32'h80);
                @(posedge clk);
                #1;
                return;
            end
            if (drop_at > 0 && k == drop_at * 8 - 1) begin
                in_valid = 1'b0;
                @(negedge clk);
                check_val($sformatf("f%0d_underrun", frame_no), {24'h0, pack_out()}, 32'h81);
                @(posedge clk);
                #1;
                return;
            end
        end
    endtask

    task automatic load_ascii();
        words.delete();
        for (int i = 0; i < 9; i++) words.push_back(8'h31 + 8'(i));
    endtask

    initial begin
        int n;
        int drop;
        int rst_at;
        bit hold;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("reset", {24'h0, pack_out()}, 32'h80);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        load_ascii();
        run_frame(-1, -1, 1'b0, 16'hFEE8);

        words.delete();
        words.push_back(8'h00);
        run_frame(-1, -1, 1'b0, 16'h0000);

        words.delete();
        words.push_back(8'hA5);
        words.push_back(8'h3C);
        run_frame(1, -1, 1'b0, 16'h0000);

        words.delete();
        words.push_back(8'hA5);
        words.push_back(8'h3C);
        words.push_back(8'h11);
        run_frame(-1, 13, 1'b0, 16'h0000);
        load_ascii();
        run_frame(-1, -1, 1'b0, 16'hFEE8);

        // Back-to-back frames with in_valid held high throughout
        load_ascii();
        run_frame(-1, -1, 1'b1, 16'hFEE8);
        words.delete();
        words.push_back(8'hC3);
        words.push_back(8'h7E);
        run_frame(-1, -1, 1'b1, ref_crc());

        for (int f = 0; f < 25; f++) begin
            words.delete();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) words.push_back(8'($urandom));
            drop = -1;
            rst_at = -1;
            if (n >= 2 && $urandom_range(0, 5) == 0) drop = $urandom_range(1, n - 1);
            else if ($urandom_range(0, 7) == 0) rst_at = $urandom_range(0, n * 8 + 16);
            hold = 1'($urandom);
            run_frame(drop, rst_at, hold, ref_crc());
        end

        in_valid = 1'b0;
        @(negedge clk);
        check_val("final_idle", {24'h0, pack_out()}, 32'h80);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
